// File: rtl/video_timing_pkg.sv
// Shared video timing description: per-axis res/porch/sync figures plus sync
// polarities, the standard modes used by the demos, and helpers that turn a
// mode into the signed counter limits (blanking negative, active from 0).
package video_timing_pkg;

  typedef struct packed {
    int h_res;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_res;
    int v_fp;
    int v_sync;
    int v_bp;
    bit h_pol;
    bit v_pol;
  } timing_t;

  localparam timing_t TIMING_480P60 = '{
    h_res: 640,  h_fp: 16,  h_sync: 96, h_bp: 48,
    v_res: 480,  v_fp: 10,  v_sync: 2,  v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  localparam timing_t TIMING_720P60 = '{
    h_res: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_res: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    h_pol: 1'b1, v_pol: 1'b1
  };

  function automatic int h_sta(timing_t t);
    return -(t.h_fp + t.h_sync + t.h_bp);
  endfunction

  function automatic int h_end(timing_t t);
    return t.h_res - 1;
  endfunction

  function automatic int hs_sta(timing_t t);
    return h_sta(t) + t.h_fp;
  endfunction

  function automatic int hs_end(timing_t t);
    return hs_sta(t) + t.h_sync - 1;
  endfunction

  function automatic int v_sta(timing_t t);
    return -(t.v_fp + t.v_sync + t.v_bp);
  endfunction

  function automatic int v_end(timing_t t);
    return t.v_res - 1;
  endfunction

  function automatic int vs_sta(timing_t t);
    return v_sta(t) + t.v_fp;
  endfunction

  function automatic int vs_end(timing_t t);
    return vs_sta(t) + t.v_sync - 1;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One axis of the raster: a signed counter running STA..END that steps when
// adv is high and wraps END->STA. Reset parks it at END so the first advance
// after reset lands on STA. The sync/active flags describe the *next*
// position so the parent can register them alongside the counter.
module video_timing_axis #(
  parameter int W        = 16,
  parameter int STA      = -160,
  parameter int END      = 639,
  parameter int SYNC_STA = -144,
  parameter int SYNC_END = -49
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                adv,
  output logic signed [W-1:0] pos,
  output logic                wrap,
  output logic                sync_d,
  output logic                active_d
);

  localparam logic signed [W-1:0] STA_V  = STA[W-1:0];
  localparam logic signed [W-1:0] END_V  = END[W-1:0];
  localparam logic signed [W-1:0] SS_V   = SYNC_STA[W-1:0];
  localparam logic signed [W-1:0] SE_V   = SYNC_END[W-1:0];
  localparam logic signed [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};

  logic signed [W-1:0] pos_q;
  logic signed [W-1:0] pos_d;

  // Next position plus the window flags evaluated at that position.
  always_comb begin
    pos_d = pos_q;
    if (adv) begin
      pos_d = (pos_q == END_V) ? STA_V : pos_q + ONE_V;
    end
    wrap     = (pos_q == END_V);
    sync_d   = (pos_d >= SS_V) && (pos_d <= SE_V);
    active_d = !pos_d[W-1];
  end

  // Position register; reset parks on the last pixel/line.
  always_ff @(posedge clk) begin
    if (srst) begin
      pos_q <= END_V;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/video_sync_gen.sv
// Pixel-clock timing generator. Two axis counters produce the signed raster
// position; syncs, enable and strobes are computed from the next position
// and registered so every output describes the pixel currently on sx/sy.
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int COORDSPC = 16,
  parameter int H_RES    = TIMING_480P60.h_res,
  parameter int H_FP     = TIMING_480P60.h_fp,
  parameter int H_SYNC   = TIMING_480P60.h_sync,
  parameter int H_BP     = TIMING_480P60.h_bp,
  parameter int V_RES    = TIMING_480P60.v_res,
  parameter int V_FP     = TIMING_480P60.v_fp,
  parameter int V_SYNC   = TIMING_480P60.v_sync,
  parameter int V_BP     = TIMING_480P60.v_bp,
  parameter bit H_POL    = TIMING_480P60.h_pol,
  parameter bit V_POL    = TIMING_480P60.v_pol,
  parameter int FCNTW    = 16
) (
  input  logic                       video_clk_pix,
  input  logic                       video_rst_pix,
  output logic signed [COORDSPC-1:0] sx,
  output logic signed [COORDSPC-1:0] sy,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       video_enable,
  output logic                       frame_start,
  output logic                       line_start,
  output logic [FCNTW-1:0]           frame_count
);

  localparam timing_t TIM = '{
    h_res: H_RES, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
    v_res: V_RES, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP,
    h_pol: H_POL, v_pol: V_POL
  };

  localparam int H_STA_C  = h_sta(TIM);
  localparam int H_END_C  = h_end(TIM);
  localparam int HS_STA_C = hs_sta(TIM);
  localparam int HS_END_C = hs_end(TIM);
  localparam int V_STA_C  = v_sta(TIM);
  localparam int V_END_C  = v_end(TIM);
  localparam int VS_STA_C = vs_sta(TIM);
  localparam int VS_END_C = vs_end(TIM);

  localparam longint C_MIN = -(longint'(1) << (COORDSPC - 1));
  localparam longint C_MAX = (longint'(1) << (COORDSPC - 1)) - 1;

  if (COORDSPC < 2 || COORDSPC > 32 ||
      H_STA_C < C_MIN || V_STA_C < C_MIN ||
      H_END_C > C_MAX || V_END_C > C_MAX) begin : g_bad_coordspc
    $error("video_sync_gen: COORDSPC=%0d cannot hold the coordinate range", COORDSPC);
  end

  if (H_SYNC < 1 || V_SYNC < 1 || H_RES < 1 || V_RES < 1) begin : g_bad_timing
    $error("video_sync_gen: sync widths and resolutions must be at least 1");
  end

  logic h_wrap, h_sync_d, h_active_d;
  logic v_wrap, v_sync_d, v_active_d;

  video_timing_axis #(
    .W(COORDSPC), .STA(H_STA_C), .END(H_END_C),
    .SYNC_STA(HS_STA_C), .SYNC_END(HS_END_C)
  ) u_h_axis (
    .clk      (video_clk_pix),
    .srst     (video_rst_pix),
    .adv      (1'b1),
    .pos      (sx),
    .wrap     (h_wrap),
    .sync_d   (h_sync_d),
    .active_d (h_active_d)
  );

  video_timing_axis #(
    .W(COORDSPC), .STA(V_STA_C), .END(V_END_C),
    .SYNC_STA(VS_STA_C), .SYNC_END(VS_END_C)
  ) u_v_axis (
    .clk      (video_clk_pix),
    .srst     (video_rst_pix),
    .adv      (h_wrap),
    .pos      (sy),
    .wrap     (v_wrap),
    .sync_d   (v_sync_d),
    .active_d (v_active_d)
  );

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_enable_q, video_enable_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [FCNTW-1:0] frame_count_q, frame_count_d;

  // Output values for the next pixel; a wrap on the current pixel means the
  // next one starts a line (and a frame when both axes wrap together).
  always_comb begin
    hsync_d        = h_sync_d ? H_POL : !H_POL;
    vsync_d        = v_sync_d ? V_POL : !V_POL;
    video_enable_d = h_active_d && v_active_d;
    line_start_d   = h_wrap;
    frame_start_d  = h_wrap && v_wrap;
    frame_count_d  = frame_start_d ? frame_count_q + FCNTW'(1) : frame_count_q;
  end

  // Output registers; frame_count resets to all ones so the first frame is 0.
  always_ff @(posedge video_clk_pix) begin
    if (video_rst_pix) begin
      hsync_q        <= !H_POL;
      vsync_q        <= !V_POL;
      video_enable_q <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_count_q  <= '1;
    end else begin
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      video_enable_q <= video_enable_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_enable = video_enable_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: three instances (480p default, 720p with a 2-bit
// frame counter, and a tiny mode that wraps many frames quickly) share a
// clock and a randomly pulsed reset. A cycle-count reference derives every
// expected output from the raster period alone.
module tb_video_sync_gen;
  import video_timing_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 480p defaults
  logic signed [15:0] a_sx, a_sy;
  logic a_hs, a_vs, a_en, a_fs, a_ls;
  logic [15:0] a_fc;
  video_sync_gen dut_a (
    .video_clk_pix(clk), .video_rst_pix(rst), .sx(a_sx), .sy(a_sy),
    .hsync(a_hs), .vsync(a_vs), .video_enable(a_en), .frame_start(a_fs),
    .line_start(a_ls), .frame_count(a_fc)
  );

  // 720p, active-high syncs, 2-bit frame counter
  logic signed [15:0] b_sx, b_sy;
  logic b_hs, b_vs, b_en, b_fs, b_ls;
  logic [1:0] b_fc;
  video_sync_gen #(
    .H_RES(TIMING_720P60.h_res), .H_FP(TIMING_720P60.h_fp),
    .H_SYNC(TIMING_720P60.h_sync), .H_BP(TIMING_720P60.h_bp),
    .V_RES(TIMING_720P60.v_res), .V_FP(TIMING_720P60.v_fp),
    .V_SYNC(TIMING_720P60.v_sync), .V_BP(TIMING_720P60.v_bp),
    .H_POL(TIMING_720P60.h_pol), .V_POL(TIMING_720P60.v_pol), .FCNTW(2)
  ) dut_b (
    .video_clk_pix(clk), .video_rst_pix(rst), .sx(b_sx), .sy(b_sy),
    .hsync(b_hs), .vsync(b_vs), .video_enable(b_en), .frame_start(b_fs),
    .line_start(b_ls), .frame_count(b_fc)
  );

  // Tiny mode: 15x8 raster, 8-bit coordinates, mixed sync polarity
  logic signed [7:0] c_sx, c_sy;
  logic c_hs, c_vs, c_en, c_fs, c_ls;
  logic [1:0] c_fc;
  video_sync_gen #(
    .COORDSPC(8), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .FCNTW(2)
  ) dut_c (
    .video_clk_pix(clk), .video_rst_pix(rst), .sx(c_sx), .sy(c_sy),
    .hsync(c_hs), .vsync(c_vs), .video_enable(c_en), .frame_start(c_fs),
    .line_start(c_ls), .frame_count(c_fc)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: cycles elapsed since reset release, or "in reset".
  logic   in_rst_m = 1'b1;
  longint t_m      = 0;

  always @(posedge clk) begin
    in_rst_m <= rst;
    t_m      <= in_rst_m ? 64'sd0 : t_m + 64'sd1;
  end

  task automatic check_inst(
    input string nm,
    input int hres, input int hfp, input int hsy, input int hbp,
    input int vres, input int vfp, input int vsy, input int vbp,
    input bit hpol, input bit vpol, input int fw,
    input longint sx, input longint sy, input bit hs, input bit vs,
    input bit en, input bit ls, input bit fs, input longint fc
  );
    longint ht, vt, col, ln, fr;
    longint esx, esy, efc;
    bit ehs, evs, een, els, efs;
    ht = hres + hfp + hsy + hbp;
    vt = vres + vfp + vsy + vbp;
    if (in_rst_m) begin
      esx = hres - 1;  esy = vres - 1;
      ehs = !hpol;     evs = !vpol;
      een = 0; els = 0; efs = 0;
      efc = (longint'(1) << fw) - 1;
    end else begin
      col = t_m % ht;
      ln  = (t_m / ht) % vt;
      fr  = t_m / (ht * vt);
      esx = col - (hfp + hsy + hbp);
      esy = ln - (vfp + vsy + vbp);
      ehs = (col >= hfp && col < hfp + hsy) ? hpol : !hpol;
      evs = (ln >= vfp && ln < vfp + vsy) ? vpol : !vpol;
      een = (col >= ht - hres) && (ln >= vt - vres);
      els = (col == 0);
      efs = (col == 0) && (ln == 0);
      efc = fr % (longint'(1) << fw);
    end
    check({nm, ".sx"}, sx, esx);
    check({nm, ".sy"}, sy, esy);
    check({nm, ".hsync"}, longint'(hs), longint'(ehs));
    check({nm, ".vsync"}, longint'(vs), longint'(evs));
    check({nm, ".video_enable"}, longint'(en), longint'(een));
    check({nm, ".line_start"}, longint'(ls), longint'(els));
    check({nm, ".frame_start"}, longint'(fs), longint'(efs));
    check({nm, ".frame_count"}, fc, efc);
  endtask

  // Compare every instance against the reference away from the active edge.
  always @(negedge clk) begin
    check_inst("480p", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 16,
               longint'(a_sx), longint'(a_sy), a_hs, a_vs, a_en, a_ls, a_fs,
               longint'(a_fc));
    check_inst("720p", 1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1, 2,
               longint'(b_sx), longint'(b_sy), b_hs, b_vs, b_en, b_ls, b_fs,
               longint'(b_fc));
    check_inst("tiny", 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b0, 2,
               longint'(c_sx), longint'(c_sy), c_hs, c_vs, c_en, c_ls, c_fs,
               longint'(c_fc));
  end

  // Segments: a reset pulse followed by a free run. The first run is long
  // enough for 480p to pass vsync and enter the active area at (0,0); later
  // runs are short and random so resets land mid-line and mid-frame.
  initial begin
    int rc;
    int rn;
    for (int s = 0; s < 21; s++) begin
      if (s == 0) begin
        rc = 5;
        rn = 38000;
      end else begin
        rc = int'($urandom_range(1, 5));
        rn = int'($urandom_range(100, 1500));
      end
      rst = 1'b1;
      repeat (rc) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (rn) @(posedge clk);
      #1;
      $display("segment %0d: reset %0d cycles, run %0d cycles, ended at 480p (%0d,%0d) frame %0d",
               s, rc, rn, a_sx, a_sy, a_fc);
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
